// File: rtl/fifo_push_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter_if
// Bundles the requester handshake and the FIFO push port of the push arbiter.
//   req_valid/req_cnt/req_data/req_last : requester beats (K of them)
//   req_ready                           : one-hot accept of the selected beat
//   fifo_can_push                       : free words reported by the FIFO
//   fifo_push/fifo_push_data            : words written into the FIFO this cycle
//   grant_id/busy/err                   : arbiter status
// The slave modport is the arbiter; the master modport is the surrounding logic.
// -----------------------------------------------------------------------------
interface fifo_push_arbiter_if #(
    parameter int W = 16,
    parameter int N = 2,
    parameter int K = 4
) ();
    localparam int WN = $clog2(N + 1) + 1;
    localparam int KW = $clog2(K);

    logic [K-1:0]                 req_valid;
    logic [K-1:0][WN-1:0]         req_cnt;
    logic [K-1:0][N-1:0][W-1:0]   req_data;
    logic [K-1:0]                 req_last;
    logic [K-1:0]                 req_ready;
    logic [WN-1:0]                fifo_can_push;
    logic [WN-1:0]                fifo_push;
    logic [N-1:0][W-1:0]          fifo_push_data;
    logic [KW-1:0]                grant_id;
    logic                         busy;
    logic                         err;

    modport master (
        output req_valid, req_cnt, req_data, req_last, fifo_can_push,
        input  req_ready, fifo_push, fifo_push_data, grant_id, busy, err
    );

    modport slave (
        input  req_valid, req_cnt, req_data, req_last, fifo_can_push,
        output req_ready, fifo_push, fifo_push_data, grant_id, busy, err
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
// Round-robin arbiter sharing the push side of one multi-push FIFO among K
// requesters. One requester is served per cycle; a beat transfers only when it
// fits into the FIFO's free space. A burst (beats until req_last) holds the
// grant. Accept and push outputs are combinational from state and inputs.
// Ports:
//   clk   : clock, state on rising edge
//   rst_n : asynchronous active-low reset; all outputs forced to 0 while low
//   bus   : fifo_push_arbiter_if.slave (requesters, FIFO push port, status)
// -----------------------------------------------------------------------------
module fifo_push_arbiter #(
    parameter int W = 16,
    parameter int N = 2,
    parameter int K = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_push_arbiter_if.slave    bus
);
    localparam int WN = $clog2(N + 1) + 1;
    localparam int KW = $clog2(K);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_r;
    logic [KW-1:0]   rr_ptr_r;
    logic [KW-1:0]   owner_r;
    logic [KW-1:0]   grant_r;
    logic            err_r;

    logic [KW-1:0]   sel_s;
    logic            sel_valid_s;
    logic [WN-1:0]   cnt_sel_s;
    logic            cnt_ok_s;
    logic            fire_s;
    logic            bad_cnt_s;
    logic [N-1:0][W-1:0] push_data_s;

    // Round-robin candidate: (base + off) mod K, works for non-power-of-two K.
    function automatic logic [KW-1:0] rr_index(input logic [KW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % K;
        return KW'(s);
    endfunction

    // Requester selection: owner while locked, else first valid from rr_ptr.
    always_comb begin
        sel_s       = '0;
        sel_valid_s = 1'b0;
        if (state_r == LOCKED) begin
            sel_s       = owner_r;
            sel_valid_s = 1'b1;
        end else begin
            for (int i = 0; i < K; i++) begin
                if (!sel_valid_s && bus.req_valid[rr_index(rr_ptr_r, i)]) begin
                    sel_s       = rr_index(rr_ptr_r, i);
                    sel_valid_s = 1'b1;
                end else begin
                    sel_valid_s = sel_valid_s;
                end
            end
        end
    end

    // Fit check; rst_n gating keeps every output quiet during reset.
    always_comb begin
        cnt_sel_s = bus.req_cnt[sel_s];
        cnt_ok_s  = (cnt_sel_s <= WN'(N));
        fire_s    = rst_n && sel_valid_s && bus.req_valid[sel_s] && cnt_ok_s &&
                    (cnt_sel_s <= bus.fifo_can_push);
        bad_cnt_s = rst_n && sel_valid_s && bus.req_valid[sel_s] && !cnt_ok_s;
    end

    // Lane masking: lanes at or above the beat count are driven to zero.
    always_comb begin
        push_data_s = '0;
        for (int l = 0; l < N; l++) begin
            if (fire_s && (WN'(l) < cnt_sel_s)) begin
                push_data_s[l] = bus.req_data[sel_s][l];
            end else begin
                push_data_s[l] = '0;
            end
        end
    end

    // Output drive; grant_id follows sel and otherwise holds the last grant.
    always_comb begin
        bus.req_ready      = fire_s ? ({{(K-1){1'b0}}, 1'b1} << sel_s) : '0;
        bus.fifo_push      = fire_s ? cnt_sel_s : '0;
        bus.fifo_push_data = push_data_s;
        if (!rst_n) begin
            bus.grant_id = '0;
        end else if (sel_valid_s) begin
            bus.grant_id = sel_s;
        end else begin
            bus.grant_id = grant_r;
        end
        bus.busy = rst_n && (state_r == LOCKED);
        bus.err  = err_r;
    end

    // Burst lock FSM, round-robin pointer, held grant and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            grant_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            if (sel_valid_s) begin
                grant_r <= sel_s;
            end
            if (bad_cnt_s) begin
                err_r <= 1'b1;
            end
            // A stall leaves state, owner and pointer untouched (head-of-line wait).
            if (fire_s) begin
                if (bus.req_last[sel_s]) begin
                    state_r <= IDLE;
                    if (sel_s == KW'(K - 1)) begin
                        rr_ptr_r <= '0;
                    end else begin
                        rr_ptr_r <= sel_s + KW'(1);
                    end
                end else begin
                    state_r <= LOCKED;
                    owner_r <= sel_s;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_push_arbiter
// Directed bench for fifo_push_arbiter (W=16, N=2, K=4). Inputs change 1 time
// unit after a rising edge; outputs are checked 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_fifo_push_arbiter;
    localparam int W  = 16;
    localparam int N  = 2;
    localparam int K  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.W(W), .N(N), .K(K)) bus ();

    fifo_push_arbiter #(.W(W), .N(N), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid     = '0;
        bus.req_cnt       = '0;
        bus.req_data      = '0;
        bus.req_last      = '0;
        bus.fifo_can_push = 3'd7;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    // Every requester offers one word (0x1000+k in lane 0, junk in lane 1), last=1.
    task automatic all_single();
        for (int k = 0; k < K; k++) begin
            bus.req_cnt[k]     = 3'd1;
            bus.req_data[k][0] = 16'h1000 + 16'(k);
            bus.req_data[k][1] = 16'hFFFF;
        end
        bus.req_last  = 4'b1111;
        bus.req_valid = 4'b1111;
    endtask

    int exp_g[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        // Reset: outputs quiet even with requests pending.
        clear_inputs();
        rst_n = 1'b0;
        all_single();
        #3;
        check_val("rst_ready", 64'(bus.req_ready), 64'(4'b0000));
        check_val("rst_push", 64'(bus.fifo_push), 64'(3'd0));
        check_val("rst_data", 64'(bus.fifo_push_data), 64'(32'h0));
        check_val("rst_grant", 64'(bus.grant_id), 64'(2'd0));
        check_val("rst_busy", 64'(bus.busy), 64'(1'b0));
        check_val("rst_err", 64'(bus.err), 64'(1'b0));
        tick();

        // Single two-word beat from req0.
        do_reset();
        bus.req_cnt[0]     = 3'd2;
        bus.req_data[0][0] = 16'hAAAA;
        bus.req_data[0][1] = 16'hBBBB;
        bus.req_last[0]    = 1'b1;
        bus.req_valid      = 4'b0001;
        settle();
        check_val("t1_ready", 64'(bus.req_ready), 64'(4'b0001));
        check_val("t1_push", 64'(bus.fifo_push), 64'(3'd2));
        check_val("t1_data", 64'(bus.fifo_push_data), 64'(32'hBBBB_AAAA));
        check_val("t1_grant", 64'(bus.grant_id), 64'(2'd0));
        tick();
        bus.req_cnt[1]  = 3'd1;
        bus.req_last[1] = 1'b1;
        bus.req_valid   = 4'b0011;
        settle();
        check_val("t1_rrptr", 64'(bus.grant_id), 64'(2'd1));
        check_val("t1_rrready", 64'(bus.req_ready), 64'(4'b0010));

        // Rotation with all four requesters valid.
        tick();
        do_reset();
        all_single();
        for (int c = 0; c < 6; c++) begin
            settle();
            check_val($sformatf("t2_grant%0d", c), 64'(bus.grant_id), 64'(exp_g[c]));
            check_val($sformatf("t2_ready%0d", c), 64'(bus.req_ready), 64'(4'b0001 << exp_g[c]));
            check_val($sformatf("t2_data%0d", c), 64'(bus.fifo_push_data),
                      64'({16'h0000, 16'h1000 + 16'(exp_g[c])}));
            tick();
        end

        // Burst from req1 while req0/req2 keep requesting.
        do_reset();
        all_single();
        bus.req_valid = 4'b0001;      // prime rr_ptr to 1
        tick();
        bus.req_valid = 4'b0111;
        bus.req_last  = 4'b1101;      // req1 not last
        settle();
        check_val("t3_g1", 64'(bus.grant_id), 64'(2'd1));
        check_val("t3_busy1", 64'(bus.busy), 64'(1'b0));
        tick();
        bus.req_valid = 4'b0101;      // owner idle for a cycle: lock kept
        settle();
        check_val("t3_wait_ready", 64'(bus.req_ready), 64'(4'b0000));
        check_val("t3_wait_grant", 64'(bus.grant_id), 64'(2'd1));
        check_val("t3_wait_busy", 64'(bus.busy), 64'(1'b1));
        tick();
        bus.req_valid = 4'b0111;
        settle();
        check_val("t3_g2", 64'(bus.grant_id), 64'(2'd1));
        check_val("t3_ready2", 64'(bus.req_ready), 64'(4'b0010));
        check_val("t3_busy2", 64'(bus.busy), 64'(1'b1));
        tick();
        bus.req_last = 4'b1111;       // beat 3 is last
        settle();
        check_val("t3_g3", 64'(bus.grant_id), 64'(2'd1));
        check_val("t3_busy3", 64'(bus.busy), 64'(1'b1));
        tick();
        settle();
        check_val("t3_g4", 64'(bus.grant_id), 64'(2'd2));
        check_val("t3_busy4", 64'(bus.busy), 64'(1'b0));

        // Head-of-line stall on FIFO room.
        tick();
        do_reset();
        all_single();
        bus.req_cnt[0]    = 3'd2;
        bus.req_valid     = 4'b0011;
        bus.fifo_can_push = 3'd1;
        settle();
        check_val("t4_push", 64'(bus.fifo_push), 64'(3'd0));
        check_val("t4_ready", 64'(bus.req_ready), 64'(4'b0000));
        check_val("t4_grant", 64'(bus.grant_id), 64'(2'd0));
        tick();
        check_val("t4_grant_hold", 64'(bus.grant_id), 64'(2'd0));
        bus.fifo_can_push = 3'd2;
        settle();
        check_val("t4_fire_ready", 64'(bus.req_ready), 64'(4'b0001));
        check_val("t4_fire_push", 64'(bus.fifo_push), 64'(3'd2));
        tick();
        bus.req_valid = 4'b0010;
        settle();
        check_val("t4_next_grant", 64'(bus.grant_id), 64'(2'd1));
        check_val("t4_next_ready", 64'(bus.req_ready), 64'(4'b0010));

        // Illegal count on req2: stall and sticky error.
        tick();
        do_reset();
        bus.req_cnt[2]  = 3'd3;
        bus.req_last[2] = 1'b1;
        bus.req_valid   = 4'b0100;
        settle();
        check_val("t5_ready", 64'(bus.req_ready), 64'(4'b0000));
        check_val("t5_push", 64'(bus.fifo_push), 64'(3'd0));
        tick();
        check_val("t5_err", 64'(bus.err), 64'(1'b1));
        bus.req_valid = 4'b0000;
        tick();
        check_val("t5_err_sticky", 64'(bus.err), 64'(1'b1));
        check_val("t5_grant_held", 64'(bus.grant_id), 64'(2'd2));

        // Async reset while locked on req3.
        do_reset();
        all_single();
        bus.req_last  = 4'b0111;
        bus.req_valid = 4'b1000;
        tick();
        check_val("t6_locked", 64'(bus.busy), 64'(1'b1));
        check_val("t6_lock_grant", 64'(bus.grant_id), 64'(2'd3));
        bus.req_valid = 4'b1111;
        rst_n = 1'b0;
        settle();
        check_val("t6_rst_ready", 64'(bus.req_ready), 64'(4'b0000));
        check_val("t6_rst_push", 64'(bus.fifo_push), 64'(3'd0));
        check_val("t6_rst_data", 64'(bus.fifo_push_data), 64'(32'h0));
        check_val("t6_rst_grant", 64'(bus.grant_id), 64'(2'd0));
        check_val("t6_rst_busy", 64'(bus.busy), 64'(1'b0));
        tick();
        rst_n = 1'b1;
        settle();
        check_val("t6_rel_grant", 64'(bus.grant_id), 64'(2'd0));
        check_val("t6_rel_busy", 64'(bus.busy), 64'(1'b0));
        check_val("t6_rel_ready", 64'(bus.req_ready), 64'(4'b0001));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
